// File: rtl/uart_loader.sv
// UART program loader: receives framed packets (A5, N, 4*N data bytes, XOR checksum)
// and writes the payload as little-endian 32-bit words into RAM starting at BASE_ADDR.
module uart_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0800,
    parameter int          TIMEOUT_CYC  = 1048576
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  word_count
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_M1     = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LEN, L_DATA, L_CSUM} ld_state_t;

    rx_state_t     r_rx_state, w_rx_next;
    logic          r_rx_s1, r_rx_s2, r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_frame_err;
    logic          w_fall, w_half_tick, w_bit_tick;

    ld_state_t     r_ld_state, w_ld_next;
    logic [7:0]    r_n;
    logic [1:0]    r_idx;
    logic [31:0]   r_word;
    logic [7:0]    r_csum;
    logic [TW-1:0] r_timer;
    logic          r_mem_we, r_busy, r_done, r_err;
    logic [31:0]   r_mem_addr, r_mem_wdata;
    logic [8:0]    r_word_count;
    logic          w_gap, w_timeout, w_abort;
    logic          w_start, w_latch_n, w_take, w_write, w_finish, w_fin_err;

    assign w_fall      = r_rx_d & ~r_rx_s2;
    assign w_half_tick = (r_cnt == HALF_M1);
    assign w_bit_tick  = (r_cnt == BIT_M1);

    // rx synchroniser plus one extra stage for falling-edge detection; idles high
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // RX next state: a start bit that reads high at mid-bit is a glitch
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_fall) w_rx_next = RX_START; else w_rx_next = RX_IDLE;
            RX_START: begin
                if (w_half_tick) begin
                    if (r_rx_s2) w_rx_next = RX_IDLE; else w_rx_next = RX_DATA;
                end else begin
                    w_rx_next = RX_START;
                end
            end
            RX_DATA:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP; else w_rx_next = RX_DATA;
            RX_STOP:  if (w_bit_tick) w_rx_next = RX_IDLE; else w_rx_next = RX_STOP;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // RX bit timing, shift register and byte/framing-error strobes
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= 3'd0;
                end
                RX_START: begin
                    if (w_half_tick) r_cnt <= '0; else r_cnt <= r_cnt + 1'b1;
                    r_bit_idx <= 3'd0;
                end
                RX_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt        <= '0;
                        r_byte       <= r_shift;
                        r_byte_valid <= r_rx_s2;
                        r_frame_err  <= ~r_rx_s2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Inter-byte gap only counts while the receiver is quiet and a packet is open
    assign w_gap     = (r_rx_state == RX_IDLE) && !r_byte_valid;
    assign w_timeout = w_gap && (r_timer == TO_M1);
    assign w_abort   = r_frame_err | w_timeout;

    // Loader state register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_ld_state <= L_IDLE;
        end else begin
            r_ld_state <= w_ld_next;
        end
    end

    // Loader next state and datapath control strobes
    always_comb begin
        w_ld_next = r_ld_state;
        w_start   = 1'b0;
        w_latch_n = 1'b0;
        w_take    = 1'b0;
        w_write   = 1'b0;
        w_finish  = 1'b0;
        w_fin_err = 1'b0;
        case (r_ld_state)
            L_IDLE: begin
                if (r_byte_valid && (r_byte == SYNC_BYTE)) begin
                    w_start   = 1'b1;
                    w_ld_next = L_LEN;
                end else begin
                    w_ld_next = L_IDLE;
                end
            end
            L_LEN: begin
                if (w_abort || (r_byte_valid && (r_byte == 8'd0))) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                    w_ld_next = L_IDLE;
                end else if (r_byte_valid) begin
                    w_latch_n = 1'b1;
                    w_ld_next = L_DATA;
                end else begin
                    w_ld_next = L_LEN;
                end
            end
            L_DATA: begin
                if (w_abort) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                    w_ld_next = L_IDLE;
                end else if (r_byte_valid) begin
                    w_take = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_write = 1'b1;
                        if ((r_word_count + 9'd1) == {1'b0, r_n}) w_ld_next = L_CSUM;
                        else w_ld_next = L_DATA;
                    end else begin
                        w_ld_next = L_DATA;
                    end
                end else begin
                    w_ld_next = L_DATA;
                end
            end
            L_CSUM: begin
                if (w_abort) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                    w_ld_next = L_IDLE;
                end else if (r_byte_valid) begin
                    w_finish  = 1'b1;
                    w_fin_err = (r_byte != r_csum);
                    w_ld_next = L_IDLE;
                end else begin
                    w_ld_next = L_CSUM;
                end
            end
            default: w_ld_next = L_IDLE;
        endcase
    end

    // Loader datapath: word assembly, checksum, RAM write port and status outputs
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_n          <= 8'd0;
            r_idx        <= 2'd0;
            r_word       <= 32'd0;
            r_csum       <= 8'd0;
            r_timer      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_wdata  <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= 9'd0;
        end else begin
            r_mem_we <= w_write;
            r_done   <= w_finish;
            if ((r_ld_state == L_IDLE) || !w_gap) r_timer <= '0;
            else r_timer <= r_timer + 1'b1;
            if (w_start) begin
                r_busy       <= 1'b1;
                r_err        <= 1'b0;
                r_word_count <= 9'd0;
                r_csum       <= 8'd0;
                r_idx        <= 2'd0;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_err  <= w_fin_err;
            end else begin
                r_busy <= r_busy;
            end
            if (w_latch_n) r_n <= r_byte;
            if (w_take) begin
                r_word[{r_idx, 3'b000} +: 8] <= r_byte;
                r_csum <= r_csum ^ r_byte;
                r_idx  <= r_idx + 2'd1;
            end
            if (w_write) begin
                r_mem_wdata  <= {r_byte, r_word[23:0]};
                r_mem_addr   <= BASE_ADDR + {21'd0, r_word_count, 2'b00};
                r_word_count <= r_word_count + 9'd1;
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serialises packets onto rx and checks RAM writes and status.
module tb_uart_loader;

    localparam int CPB = 8;
    localparam int TO  = 300;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        rx = 1'b1;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          overlap = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic        last_err = 1'b0;
    logic [8:0]  last_wc = 9'd0;
    logic [7:0]  pkt [$];

    uart_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (32'h0000_0800),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Logs RAM writes and done pulses away from the active edge
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= mem_addr;
                wr_data[wr_cnt] <= mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            last_err <= err;
            last_wc  <= word_count;
        end
        if (mem_we && done) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; (i < budget) && (done_cnt < target); i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we",    32'(mem_we),     32'd0);
        check("rst_addr",  mem_addr,        32'h0000_0800);
        check("rst_wdata", mem_wdata,       32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_wc",    32'(word_count), 32'd0);
        resetn = 1'b0;
        repeat (4) @(negedge clk);

        // Single good word
        send_byte(8'hA5, 1'b1);
        check("t1_busy", 32'(busy), 32'd1);
        pkt = {8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_pkt();
        wait_done(1, 200);
        check("t1_done",  32'(done_cnt), 32'd1);
        check("t1_wrcnt", 32'(wr_cnt),   32'd1);
        check("t1_addr",  wr_addr[0],    32'h0000_0800);
        check("t1_data",  wr_data[0],    32'h1234_5678);
        check("t1_err",   32'(last_err), 32'd0);
        check("t1_wc",    32'(last_wc),  32'd1);
        check("t1_busy0", 32'(busy),     32'd0);
        check("t1_done0", 32'(done),     32'd0);

        // Three words, good checksum
        pkt = {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
        send_pkt();
        wait_done(2, 200);
        check("t2_wrcnt", 32'(wr_cnt),   32'd4);
        check("t2_addr0", wr_addr[1],    32'h0000_0800);
        check("t2_addr1", wr_addr[2],    32'h0000_0804);
        check("t2_addr2", wr_addr[3],    32'h0000_0808);
        check("t2_data0", wr_data[1],    32'h0403_0201);
        check("t2_data1", wr_data[2],    32'h0807_0605);
        check("t2_data2", wr_data[3],    32'h0C0B_0A09);
        check("t2_err",   32'(last_err), 32'd0);
        check("t2_wc",    32'(last_wc),  32'd3);

        // Three words, corrupted checksum
        pkt[14] = 8'h0D;
        send_pkt();
        wait_done(3, 200);
        check("t2b_wrcnt", 32'(wr_cnt),   32'd7);
        check("t2b_addr2", wr_addr[6],    32'h0000_0808);
        check("t2b_data2", wr_data[6],    32'h0C0B_0A09);
        check("t2b_err",   32'(last_err), 32'd1);
        check("t2b_wc",    32'(last_wc),  32'd3);

        // Quarter-bit glitch on idle line
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("gl_wrcnt", 32'(wr_cnt),   32'd7);
        check("gl_done",  32'(done_cnt), 32'd3);
        check("gl_busy",  32'(busy),     32'd0);

        // Noise bytes before sync
        pkt = {8'h00, 8'hFF, 8'h5A};
        send_pkt();
        check("nz_wrcnt", 32'(wr_cnt), 32'd7);
        check("nz_busy",  32'(busy),   32'd0);
        pkt = {8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_pkt();
        wait_done(4, 200);
        check("nz_wrcnt2", 32'(wr_cnt),   32'd8);
        check("nz_addr",   wr_addr[7],    32'h0000_0800);
        check("nz_data",   wr_data[7],    32'hDEAD_BEEF);
        check("nz_err",    32'(last_err), 32'd0);

        // Framing error on third data byte, then recovery
        pkt = {8'hA5, 8'h01, 8'h11, 8'h22};
        send_pkt();
        send_byte(8'h33, 1'b0);
        wait_done(5, 100);
        check("fe_done",  32'(done_cnt), 32'd5);
        check("fe_err",   32'(last_err), 32'd1);
        check("fe_busy",  32'(busy),     32'd0);
        check("fe_wrcnt", 32'(wr_cnt),   32'd8);
        check("fe_wc",    32'(last_wc),  32'd0);
        pkt = {8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_pkt();
        wait_done(6, 200);
        check("fr_wrcnt", 32'(wr_cnt),   32'd9);
        check("fr_addr",  wr_addr[8],    32'h0000_0800);
        check("fr_data",  wr_data[8],    32'h0403_0201);
        check("fr_err",   32'(last_err), 32'd0);

        // Timeout after first of two words
        pkt = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
        send_pkt();
        repeat (TO / 2) @(negedge clk);
        check("to_early", 32'(done_cnt), 32'd6);
        check("to_busy1", 32'(busy),     32'd1);
        wait_done(7, 2 * TO);
        check("to_done",  32'(done_cnt), 32'd7);
        check("to_wrcnt", 32'(wr_cnt),   32'd10);
        check("to_addr",  wr_addr[9],    32'h0000_0800);
        check("to_data",  wr_data[9],    32'h0403_0201);
        check("to_err",   32'(last_err), 32'd1);
        check("to_wc",    32'(last_wc),  32'd1);
        check("to_busy0", 32'(busy),     32'd0);

        // Asynchronous reset mid-DATA
        pkt = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_pkt();
        check("rs_wc_pre", 32'(word_count), 32'd1);
        #2 resetn = 1'b1;
        #1;
        check("rs_we",   32'(mem_we),     32'd0);
        check("rs_addr", mem_addr,        32'h0000_0800);
        check("rs_busy", 32'(busy),       32'd0);
        check("rs_wc",   32'(word_count), 32'd0);
        check("rs_err",  32'(err),        32'd0);
        check("rs_done", 32'(done),       32'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rs_nodone", 32'(done_cnt), 32'd7);
        pkt = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_pkt();
        wait_done(8, 200);
        check("rs2_wrcnt", 32'(wr_cnt),   32'd12);
        check("rs2_addr",  wr_addr[11],   32'h0000_0800);
        check("rs2_data",  wr_data[11],   32'h4433_2211);
        check("rs2_err",   32'(last_err), 32'd0);
        check("overlap",   32'(overlap),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Host-to-CPU program loader: deserialises a UART byte stream, validates a framed packet and writes 32-bit words into the instruction/data RAM region the CPU fetches from at addresses ≥ 0x800.
- It is the writer side of the RAM the CPU only reads. It sits beside the memory-mapped UART device and drives the RAM write port.
- While a load is in progress it raises busy so the top level can stall clk_cpu.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); must be ≥ 4.
- BASE_ADDR, 32'h0000_0800, byte address of the first word written.
- TIMEOUT_CYC, 1048576, idle cycles allowed between bytes inside a packet before abort.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous reset, active-high: asserted when 1. The codebase port name is kept.
- rx  input  1  UART serial in, idle high, asynchronous to clk.
- mem_we  output  1  one-cycle RAM write strobe.
- mem_addr  output  32  byte address of the write, word aligned.
- mem_wdata  output  32  write data.
- busy  output  1  high while a packet is being received.
- done  output  1  one-cycle pulse when a packet ends, by success or abort.
- err  output  1  status of the last packet; valid from the done pulse onward.
- word_count  output  9  number of words written in the current or last packet.

Behaviour:
- Reset (async, resetn=1):
  - All outputs go to 0 and mem_addr goes to BASE_ADDR.
  - The rx synchroniser flops preset to 1; the RX and loader FSMs go to IDLE.
  - A reset mid-packet abandons it silently: no done pulse.
- RX deserialiser (8N1, LSB first):
  - rx passes through a 2-flop synchroniser.
  - Idle detects a 1→0 edge and then waits CLKS_PER_BIT/2 cycles to re-sample the start bit. If the start bit reads 1, it is a glitch: return to idle.
  - Each of the 8 data bits is sampled every CLKS_PER_BIT cycles, then the stop bit is sampled.
  - Stop=1: byte_valid pulses for one cycle with the byte. Stop=0: framing error pulse, no byte.
  - A new start edge is accepted immediately after the stop-bit sample.
- Packet format: 0xA5, N (word count), 4·N data bytes (little-endian per word), then CHK = XOR of all data bytes.
- Loader FSM:
  - IDLE: every byte except 0xA5 is ignored. On 0xA5: clear err, word_count, the checksum accumulator and the byte index; go to LEN with busy=1.
  - LEN: N=0 aborts (err=1, done). Otherwise latch N and go to DATA.
  - DATA: shift each byte into a word register at position idx (0..3) and fold it into the checksum.
    - On the 4th byte, the next cycle has mem_we=1, mem_wdata=word and mem_addr=BASE_ADDR+4·word_count; word_count increments in that same cycle.
    - mem_addr/mem_wdata hold their values until the next write.
    - After word N, go to CSUM.
  - CSUM: the received byte is compared with the accumulator. Equal: err=0, otherwise err=1. Pulse done, drop busy, return to IDLE.
- Abort conditions (err=1, one-cycle done, busy=0, back to IDLE):
  - a framing error while busy;
  - a TIMEOUT_CYC-cycle gap between bytes while busy.
  - Words already written stay written; word_count reports them.
- Inside a packet, 0xA5 is ordinary data.
- Address arithmetic is 32-bit and wraps modulo 2^32; at most 255 words, so no overflow in practice.
- done and mem_we never assert in the same cycle. done follows the final mem_we by at least one byte time.

Test Plan:
- Good packet: A5 01 78 56 34 12 08 → one mem_we with addr 0x800, data 0x12345678; then done=1, err=0, word_count=1, busy low after done.
- Three words A5 03, 12 data bytes, correct CHK → mem_we at 0x800, 0x804, 0x808 in order, word_count=3, err=0. A corrupted CHK gives the same three writes, then err=1.
- Noise then sync: bytes 00 FF 5A before A5 01 … → no writes until after A5; the packet then completes normally. A 1/4-bit low glitch on idle rx produces no byte.
- Framing error: a bad stop bit on the 3rd data byte → no mem_we, done+err, busy=0. The next valid packet loads fine.
- Timeout: A5 02 plus 4 bytes, then silence for TIMEOUT_CYC cycles → one write at 0x800, then done, err=1, word_count=1.
- Reset mid-DATA: assert resetn asynchronously → all outputs 0 immediately, no done pulse. A following packet loads from 0x800.
